// File: rtl/ex_issue_ctrl.sv
// EX-stage issue controller: registers ID micro-ops into EX, decodes operand/forwarding selects,
// stalls on load-use (or on any RAW hazard when forwarding is off) and sequences multi-cycle MULDIV ops.
module ex_issue_ctrl #(
  parameter int MD_LAT = 4,
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  output logic       id_ready,
  input  logic [2:0] id_opClass,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_useRs1,
  input  logic       id_useRs2,
  input  logic [4:0] id_rd,
  input  logic       id_regWrite,
  input  logic       id_isLoad,
  input  logic [4:0] mem_rd,
  input  logic       mem_regWrite,
  input  logic       ex_ready,
  input  logic       flush,
  output logic       ex_valid,
  output logic       ex_busy,
  output logic       ex_selA,
  output logic [1:0] ex_selB,
  output logic [1:0] ex_fwdA,
  output logic [1:0] ex_fwdB,
  output logic [4:0] ex_rd,
  output logic       ex_regWrite,
  output logic       ex_isLoad
);

  typedef enum logic [1:0] {IDLE, EXEC, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MD_LAT - 2);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic       occupied, slot_free, accept, is_md;
  logic       rs1_live, rs2_live, rs1_ex, rs2_ex, rs1_mem, rs2_mem;
  logic       load_use, raw_stall, hazard;
  logic       sel_a, rw_dec;
  logic [1:0] sel_b, fwd_a, fwd_b;

  assign occupied  = (state != IDLE);
  assign slot_free = (state == IDLE) || (((state == EXEC) || (state == DONE)) && ex_ready);

  // x0 is never a real dependency, so it is filtered before any match
  assign rs1_live = id_useRs1 && (id_rs1 != 5'd0);
  assign rs2_live = id_useRs2 && (id_rs2 != 5'd0);
  assign rs1_ex   = rs1_live && occupied && ex_regWrite && (id_rs1 == ex_rd);
  assign rs2_ex   = rs2_live && occupied && ex_regWrite && (id_rs2 == ex_rd);
  assign rs1_mem  = rs1_live && mem_regWrite && (id_rs1 == mem_rd);
  assign rs2_mem  = rs2_live && mem_regWrite && (id_rs2 == mem_rd);

  assign load_use  = ex_isLoad && (rs1_ex || rs2_ex);
  assign raw_stall = !FWD_EN && (rs1_ex || rs2_ex || rs1_mem || rs2_mem);
  assign hazard    = load_use || raw_stall;

  assign id_ready = !rst && !flush && !hazard && slot_free;
  assign accept   = id_valid && id_ready;
  assign is_md    = (id_opClass == 3'd5);

  // EX match wins: that op is the younger producer
  assign fwd_a = !FWD_EN ? 2'b00 : rs1_ex ? 2'b01 : rs1_mem ? 2'b10 : 2'b00;
  assign fwd_b = !FWD_EN ? 2'b00 : rs2_ex ? 2'b01 : rs2_mem ? 2'b10 : 2'b00;

  always_comb begin
    sel_a  = 1'b0;
    sel_b  = 2'b00;
    rw_dec = id_regWrite;
    case (id_opClass)
      3'd0: ;
      3'd1: sel_b = 2'b01;
      3'd2: begin sel_a = 1'b1; sel_b = 2'b01; end
      3'd3: begin sel_a = 1'b1; sel_b = 2'b10; end
      3'd4: sel_b = 2'b01;
      3'd5: ;
      default: rw_dec = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        BUSY: begin
          if (cnt == 4'd0) state_nxt = DONE;
          else             cnt_nxt   = cnt - 4'd1;
        end
        default: begin
          if (slot_free) begin
            state_nxt = IDLE;
            if (accept) begin
              state_nxt = is_md ? BUSY : EXEC;
              cnt_nxt   = is_md ? CNT_INIT : 4'd0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      ex_selA     <= 1'b0;
      ex_selB     <= 2'b00;
      ex_fwdA     <= 2'b00;
      ex_fwdB     <= 2'b00;
      ex_rd       <= 5'd0;
      ex_regWrite <= 1'b0;
      ex_isLoad   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (flush) begin
        ex_regWrite <= 1'b0;
        ex_isLoad   <= 1'b0;
      end else if (accept) begin
        ex_selA     <= sel_a;
        ex_selB     <= sel_b;
        ex_fwdA     <= fwd_a;
        ex_fwdB     <= fwd_b;
        ex_rd       <= id_rd;
        ex_regWrite <= rw_dec;
        ex_isLoad   <= id_isLoad;
      end
    end
  end

  assign ex_valid = (state == EXEC) || (state == DONE);
  assign ex_busy  = (state == BUSY);

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed walk through the issue scenarios followed by random traffic, all checked against an EX-slot model.
module tb_ex_issue_ctrl;
  localparam int MD_LAT = 4;
  localparam bit FWD_EN = 1'b1;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_ready;
  logic [2:0] id_opClass;
  logic [4:0] id_rs1, id_rs2, id_rd, mem_rd, ex_rd;
  logic       id_useRs1, id_useRs2, id_regWrite, id_isLoad, mem_regWrite;
  logic       ex_ready, flush, ex_valid, ex_busy, ex_selA, ex_regWrite, ex_isLoad;
  logic [1:0] ex_selB, ex_fwdA, ex_fwdB;

  ex_issue_ctrl #(.MD_LAT(MD_LAT), .FWD_EN(FWD_EN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_opClass(id_opClass), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2), .id_rd(id_rd),
    .id_regWrite(id_regWrite), .id_isLoad(id_isLoad),
    .mem_rd(mem_rd), .mem_regWrite(mem_regWrite), .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_busy(ex_busy), .ex_selA(ex_selA), .ex_selB(ex_selB),
    .ex_fwdA(ex_fwdA), .ex_fwdB(ex_fwdB), .ex_rd(ex_rd),
    .ex_regWrite(ex_regWrite), .ex_isLoad(ex_isLoad)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model of the EX slot: occupancy plus cycles left before the result is presented
  bit         m_occ = 1'b0, m_killed = 1'b1;
  int         m_rem = 0;
  logic       m_selA, m_rw, m_ld;
  logic [1:0] m_selB, m_fwdA, m_fwdB;
  logic [4:0] m_rd;
  bit         pipe = 1'b1;
  logic [4:0] p_rd = 5'd0;
  logic       p_rw = 1'b0;
  logic       rec_ready;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] s, input logic u);
    if (!FWD_EN || !u || s == 5'd0) return 2'b00;
    if (m_occ && m_rw && s == m_rd) return 2'b01;
    if (mem_regWrite && s == mem_rd) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_dep(input logic [4:0] s, input logic u, input logic [4:0] d);
    return u && s != 5'd0 && s == d;
  endfunction

  task automatic op(input logic v, input logic [2:0] c, input logic [4:0] r1, input logic u1,
                    input logic [4:0] r2, input logic u2, input logic [4:0] d, input logic w,
                    input logic l);
    id_valid = v; id_opClass = c; id_rs1 = r1; id_useRs1 = u1; id_rs2 = r2; id_useRs2 = u2;
    id_rd = d; id_regWrite = w; id_isLoad = l;
  endtask

  task automatic step();
    logic v, ex_hit, mem_hit, haz, rdy, acc;
    logic [1:0] fa, fb, sb;
    logic sa, rw;
    if (pipe) begin mem_rd = p_rd; mem_regWrite = p_rw; end
    #1;
    v       = m_occ && m_rem == 0;
    ex_hit  = m_occ && m_rw && (m_dep(id_rs1, id_useRs1, m_rd) || m_dep(id_rs2, id_useRs2, m_rd));
    mem_hit = mem_regWrite && (m_dep(id_rs1, id_useRs1, mem_rd) || m_dep(id_rs2, id_useRs2, mem_rd));
    haz     = (ex_hit && m_ld) || (!FWD_EN && (ex_hit || mem_hit));
    rdy     = !rst && !flush && !haz && (!m_occ || (v && ex_ready));
    chk("id_ready", 16'(id_ready), 16'(rdy));
    chk("ex_valid", 16'(ex_valid), 16'(v));
    chk("ex_busy", 16'(ex_busy), 16'(m_occ && m_rem != 0));
    if (m_occ) begin
      chk("ex_sel", {13'd0, ex_selA, ex_selB}, {13'd0, m_selA, m_selB});
      chk("ex_fwd", {12'd0, ex_fwdA, ex_fwdB}, {12'd0, m_fwdA, m_fwdB});
      chk("ex_dst", {9'd0, ex_rd, ex_regWrite, ex_isLoad}, {9'd0, m_rd, m_rw, m_ld});
    end else if (m_killed) begin
      chk("ex_regWrite_clr", 16'(ex_regWrite), 16'd0);
    end
    rec_ready = id_ready;
    fa  = m_fwd(id_rs1, id_useRs1);
    fb  = m_fwd(id_rs2, id_useRs2);
    acc = id_valid && rdy;
    rw  = id_regWrite;
    case (id_opClass)
      3'd1, 3'd4: begin sa = 1'b0; sb = 2'b01; end
      3'd2:       begin sa = 1'b1; sb = 2'b01; end
      3'd3:       begin sa = 1'b1; sb = 2'b10; end
      3'd0, 3'd5: begin sa = 1'b0; sb = 2'b00; end
      default:    begin sa = 1'b0; sb = 2'b00; rw = 1'b0; end
    endcase
    @(posedge clk);
    if (rst || flush) begin
      m_occ = 1'b0; m_killed = 1'b1; p_rw = 1'b0;
    end else if (m_occ && m_rem > 0) begin
      m_rem--; p_rw = 1'b0;
    end else begin
      p_rw = v && ex_ready && m_rw;
      p_rd = m_rd;
      if (v && ex_ready) m_occ = 1'b0;
      if (acc) begin
        m_occ = 1'b1; m_killed = 1'b0;
        m_rem = (id_opClass == 3'd5) ? MD_LAT - 1 : 0;
        m_selA = sa; m_selB = sb; m_fwdA = fa; m_fwdB = fb;
        m_rd = id_rd; m_rw = rw; m_ld = id_isLoad;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1; mem_rd = 5'd0; mem_regWrite = 1'b0;
    op(1, 0, 1, 1, 2, 1, 10, 1, 0);
    @(negedge clk);
    step();
    chk("rst_ready", 16'(rec_ready), 16'd0);
    chk("rst_outs", {4'd0, ex_valid, ex_busy, ex_selA, ex_selB, ex_fwdA, ex_fwdB, ex_regWrite, ex_isLoad},
        16'd0);
    chk("rst_rd", 16'(ex_rd), 16'd0);
    rst = 1'b0;

    // RR, RI, AUIPC, LINK back to back
    step();                          chk("rr_sel", {ex_valid, ex_selA, ex_selB}, 16'b1000);
    op(1, 1, 3, 1, 0, 0, 11, 1, 0); step(); chk("ri_sel", {ex_valid, ex_selA, ex_selB}, 16'b1001);
    op(1, 2, 0, 0, 0, 0, 12, 1, 0); step(); chk("auipc_sel", {ex_valid, ex_selA, ex_selB}, 16'b1101);
    op(1, 3, 0, 0, 0, 0, 13, 1, 0); step(); chk("link_sel", {ex_valid, ex_selA, ex_selB}, 16'b1110);

    // forwarding from EX, from MEM, and never for x0
    op(1, 0, 1, 1, 2, 1, 5, 1, 0); step();
    op(1, 0, 5, 1, 5, 1, 6, 1, 0); step(); chk("fwd_ex", {ex_fwdA, ex_fwdB}, 16'b0101);
    op(1, 0, 5, 1, 3, 1, 0, 1, 0); step(); chk("fwd_mem", {ex_fwdA, ex_fwdB}, 16'b1000);
    op(1, 0, 0, 1, 0, 1, 4, 1, 0); step(); chk("fwd_x0", {ex_fwdA, ex_fwdB}, 16'b0000);
    op(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();

    // load-use bubble
    op(1, 1, 1, 1, 0, 0, 7, 1, 1); step();
    op(1, 0, 1, 1, 7, 1, 9, 1, 0); step();
    chk("lu_stall", 16'(rec_ready), 16'd0);
    chk("lu_bubble", 16'(ex_valid), 16'd0);
    step();
    chk("lu_issue", 16'(rec_ready), 16'd1);
    chk("lu_fwd", {ex_valid, ex_fwdA, ex_fwdB}, 16'b10010);
    op(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // MULDIV occupies EX for MD_LAT cycles, next op issues on the result cycle
    op(1, 5, 1, 1, 2, 1, 3, 1, 0); step();
    chk("md_accept", 16'(rec_ready), 16'd1);
    op(1, 0, 1, 1, 2, 1, 4, 1, 0);
    for (int i = 1; i < MD_LAT; i++) begin
      chk("md_busy", {ex_busy, ex_valid}, 16'b10);
      step();
      chk("md_hold", 16'(rec_ready), 16'd0);
    end
    chk("md_done", {ex_busy, ex_valid, 3'd0, ex_rd}, {2'b01, 3'd0, 5'd3});
    step();
    chk("md_next", 16'(rec_ready), 16'd1);
    chk("md_next_rd", {ex_valid, ex_rd}, {1'b1, 5'd4});
    op(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // flush mid-BUSY
    op(1, 5, 1, 1, 2, 1, 3, 1, 0); step();
    op(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    flush = 1'b1; step();
    chk("fl_ready", 16'(rec_ready), 16'd0);
    flush = 1'b0;
    chk("fl_state", {ex_valid, ex_busy, ex_regWrite}, 16'd0);
    op(1, 0, 1, 1, 2, 1, 8, 1, 0); step();
    chk("fl_reissue", 16'(rec_ready), 16'd1);
    op(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // downstream stall holds EX stable, release accepts the waiting op
    op(1, 0, 1, 1, 2, 1, 20, 1, 0); step();
    ex_ready = 1'b0;
    op(1, 0, 20, 1, 2, 1, 21, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_ready", 16'(rec_ready), 16'd0);
      chk("st_hold", {ex_valid, ex_selA, ex_selB, ex_fwdA, ex_fwdB, ex_rd}, {1'b1, 3'b000, 4'b0000, 5'd20});
    end
    ex_ready = 1'b1; step();
    chk("st_release", 16'(rec_ready), 16'd1);
    chk("st_next", {ex_fwdA, ex_rd}, {2'b01, 5'd21});
    op(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // random traffic with a free-running MEM stage
    pipe = 1'b0;
    repeat (3000) begin
      rst          = ($urandom_range(0, 199) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      ex_ready     = ($urandom_range(0, 3) != 0);
      mem_rd       = 5'($urandom_range(0, 7));
      mem_regWrite = 1'($urandom_range(0, 1));
      op(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
         5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
         5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 3) == 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
